seg_scan_driver: RTL and testbench

- Parametrised successor to the four-digit combinational decimal display path.
- Converts a binary value to DIGITS BCD digits with a sequential double-dabble engine, one bit per clock, instead of dividers.
- Holds the result in a display register and time-multiplexes the digits onto one shared segment bus with one-hot digit enables.
- Adds a load/ready handshake, an overflow flag, leading-zero blanking and whole-display blanking.

---
 rtl/seg_scan_if.sv | 27 ++
 rtl/seg_scan_driver.sv | 174 +++++++++++++++++
 tb/tb_seg_scan_driver.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// Load/ready handshake bundle for the scanned decimal display driver.
// master = value producer, slave = converter.
interface seg_scan_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] value;
   logic             load;
   logic             ready;
   logic             done;
   logic             overflow;

   modport master (
      output value,
      output load,
      input  ready,
      input  done,
      input  overflow
   );

   modport slave (
      input  value,
      input  load,
      output ready,
      output done,
      output overflow
   );
endinterface

// File: rtl/seg_scan_driver.sv
// Binary-to-BCD converter (serial double dabble, one bit per clock) feeding a
// display register that is time-multiplexed onto a shared active-low segment bus.
module seg_scan_driver #(
   parameter int WIDTH    = 32,
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 50000
) (
   input  logic              clk,
   input  logic              reset_n,
   seg_scan_if.slave         bus,
   input  logic              lz_blank,
   input  logic              blank,
   output logic [6:0]        seg,
   output logic [DIGITS-1:0] digit_en
);

   localparam int BCDW = 4 * DIGITS;
   localparam int CNTW = $clog2(WIDTH);
   localparam int SCW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  bin_q, bin_d;
   logic [BCDW-1:0]   bcd_q, bcd_d;
   logic              sticky_q, sticky_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic [BCDW-1:0]   disp_q, disp_d;
   logic              ovf_q, ovf_d;
   logic              done_q, done_d;
   logic [SCW-1:0]    scan_cnt_q, scan_cnt_d;
   logic [IDXW-1:0]   scan_idx_q, scan_idx_d;
   logic [6:0]        seg_q, seg_d;
   logic [DIGITS-1:0] digit_en_q, digit_en_d;

   logic [BCDW-1:0]   bcd_adj;
   logic [BCDW-1:0]   bcd_shift;
   logic              carry;
   logic              last;
   logic [3:0]        cur_digit;
   logic              upper_nz;
   logic [6:0]        decoded;
   logic              wrap;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         bin_q      <= '0;
         bcd_q      <= '0;
         sticky_q   <= 1'b0;
         cnt_q      <= '0;
         disp_q     <= '0;
         ovf_q      <= 1'b0;
         done_q     <= 1'b0;
         scan_cnt_q <= '0;
         scan_idx_q <= '0;
         seg_q      <= 7'h7F;
         digit_en_q <= '0;
      end else begin
         state_q    <= state_d;
         bin_q      <= bin_d;
         bcd_q      <= bcd_d;
         sticky_q   <= sticky_d;
         cnt_q      <= cnt_d;
         disp_q     <= disp_d;
         ovf_q      <= ovf_d;
         done_q     <= done_d;
         scan_cnt_q <= scan_cnt_d;
         scan_idx_q <= scan_idx_d;
         seg_q      <= seg_d;
         digit_en_q <= digit_en_d;
      end
   end

   // Conversion FSM. The final SHIFT cycle also accepts a new load so that
   // back-to-back conversions run at one result every WIDTH cycles.
   always_comb begin
      state_d  = state_q;
      bin_d    = bin_q;
      bcd_d    = bcd_q;
      sticky_d = sticky_q;
      cnt_d    = cnt_q;
      disp_d   = disp_q;
      ovf_d    = ovf_q;
      done_d   = 1'b0;

      bcd_adj = bcd_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[i*4 +: 4] >= 4'd5) begin
            bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
         end
      end
      {carry, bcd_shift} = {bcd_adj, bin_q[WIDTH-1]};
      last = (state_q == SHIFT) && (cnt_q == CNTW'(WIDTH - 1));

      if (state_q == SHIFT) begin
         bcd_d    = bcd_shift;
         bin_d    = {bin_q[WIDTH-2:0], 1'b0};
         sticky_d = sticky_q | carry;
         cnt_d    = cnt_q + CNTW'(1);
         if (last) begin
            disp_d  = bcd_shift;
            ovf_d   = sticky_q | carry;
            done_d  = 1'b1;
            state_d = IDLE;
         end
      end

      if (bus.load && ((state_q == IDLE) || last)) begin
         bin_d    = bus.value;
         bcd_d    = '0;
         sticky_d = 1'b0;
         cnt_d    = '0;
         state_d  = SHIFT;
      end
   end

   // Scan timing, digit select and segment decode with blanking.
   always_comb begin
      scan_cnt_d = scan_cnt_q;
      scan_idx_d = scan_idx_q;
      cur_digit  = 4'd0;
      upper_nz   = 1'b0;
      decoded    = 7'h7F;
      seg_d      = 7'h7F;
      digit_en_d = '0;

      wrap = (scan_cnt_q == SCW'(SCAN_DIV - 1));
      if (wrap) begin
         scan_cnt_d = '0;
         scan_idx_d = (scan_idx_q == IDXW'(DIGITS - 1)) ? '0 : scan_idx_q + IDXW'(1);
      end else begin
         scan_cnt_d = scan_cnt_q + SCW'(1);
      end

      for (int i = 0; i < DIGITS; i++) begin
         if (scan_idx_q == IDXW'(i)) begin
            cur_digit = disp_q[i*4 +: 4];
         end
         if ((IDXW'(i) >= scan_idx_q) && (disp_q[i*4 +: 4] != 4'd0)) begin
            upper_nz = 1'b1;
         end
      end

      case (cur_digit)
         4'd0:    decoded = 7'h40;
         4'd1:    decoded = 7'h79;
         4'd2:    decoded = 7'h24;
         4'd3:    decoded = 7'h30;
         4'd4:    decoded = 7'h19;
         4'd5:    decoded = 7'h12;
         4'd6:    decoded = 7'h02;
         4'd7:    decoded = 7'h78;
         4'd8:    decoded = 7'h00;
         4'd9:    decoded = 7'h10;
         default: decoded = 7'h7F;
      endcase

      if (blank || (lz_blank && (scan_idx_q != '0) && !upper_nz)) begin
         seg_d = 7'h7F;
      end else begin
         seg_d = decoded;
      end
      digit_en_d = DIGITS'(1) << scan_idx_q;
   end

   assign bus.ready    = (state_q == IDLE);
   assign bus.done     = done_q;
   assign bus.overflow = ovf_q;
   assign seg          = seg_q;
   assign digit_en     = digit_en_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized scoreboard bench for seg_scan_driver: an arithmetic reference model
// predicts conversions, display contents and the scan pattern cycle by cycle.
module tb_seg_scan_driver;

   localparam int W  = 32;
   localparam int D  = 4;
   localparam int SD = 4;

   typedef struct {
      longint done_cyc;
      bit     ovf;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         lz_blank;
   logic         blank;
   logic [6:0]   seg;
   logic [D-1:0] digit_en;

   seg_scan_if #(.WIDTH(W)) bus ();

   seg_scan_driver #(.WIDTH(W), .DIGITS(D), .SCAN_DIV(SD)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus),
      .lz_blank (lz_blank),
      .blank    (blank),
      .seg      (seg),
      .digit_en (digit_en)
   );

   always #5 clk = ~clk;

   int         tests = 0;
   int         fails = 0;
   exp_t       sb_q[$];
   longint     cyc = 0;
   int         busy = 0;
   longint     pend_val = 0;
   longint     disp_val = 0;
   bit         model_ovf = 1'b0;
   bit         exp_done = 1'b0;
   bit         exp_ready = 1'b1;
   logic [6:0] exp_seg = 7'h7F;
   logic [D-1:0] exp_en = '0;
   longint     scan_k = 0;
   logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   function automatic longint pow10(input int n);
      longint p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Reference model: display = value mod 10^D, overflow = value >= 10^D,
   // result WIDTH edges after acceptance; scan slot = SD edges per digit.
   always @(posedge clk) begin
      int idx;
      int prev;
      cyc++;
      if (!reset_n) begin
         busy = 0; disp_val = 0; model_ovf = 1'b0; sb_q.delete();
         scan_k = 0; exp_seg = 7'h7F; exp_en = '0; exp_done = 1'b0; exp_ready = 1'b1;
      end else begin
         idx = int'((scan_k / SD) % D);
         scan_k++;
         exp_en = D'(1) << idx;
         if (blank)
            exp_seg = 7'h7F;
         else if (lz_blank && idx > 0 && (disp_val / pow10(idx)) == 0)
            exp_seg = 7'h7F;
         else
            exp_seg = seg_tab[int'((disp_val / pow10(idx)) % 10)];

         prev = busy;
         exp_done = 1'b0;
         if (prev > 0) begin
            busy = prev - 1;
            if (busy == 0) begin
               disp_val  = pend_val % pow10(D);
               model_ovf = (pend_val >= pow10(D));
               exp_done  = 1'b1;
            end
         end
         if (bus.load && prev <= 1) begin
            pend_val = longint'(bus.value);
            busy = W;
            sb_q.push_back('{cyc + W, (pend_val >= pow10(D))});
         end
         exp_ready = (busy == 0);
      end
   end

   // Monitor: compares every cycle and pops the scoreboard on each done pulse.
   always @(negedge clk) begin
      exp_t e;
      if (!reset_n) begin
         check_output("rst_ready", 64'(bus.ready), 64'(1));
         check_output("rst_done", 64'(bus.done), 64'(0));
         check_output("rst_seg", 64'(seg), 64'h7F);
         check_output("rst_digit_en", 64'(digit_en), 64'(0));
      end else begin
         check_output("digit_en", 64'(digit_en), 64'(exp_en));
         check_output("seg", 64'(seg), 64'(exp_seg));
         check_output("ready", 64'(bus.ready), 64'(exp_ready));
         check_output("done", 64'(bus.done), 64'(exp_done));
         check_output("overflow_level", 64'(bus.overflow), 64'(model_ovf));
         if (bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
               check_output("done_unexpected", 64'(1), 64'(0));
            end else begin
               e = sb_q.pop_front();
               check_output("done_time", 64'(cyc), 64'(e.done_cyc));
               check_output("done_overflow", 64'(bus.overflow), 64'(e.ovf));
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (bus.ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_output("ready_timeout", 64'(bus.ready), 64'(1));
   endtask

   task automatic apply_stimulus(input logic [W-1:0] v);
      @(negedge clk);
      bus.value = v;
      bus.load  = 1'b1;
      @(negedge clk);
      bus.load  = 1'b0;
      wait_ready();
      idle(2 * SD * D);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check_output("async_rst_ready", 64'(bus.ready), 64'(1));
      check_output("async_rst_done", 64'(bus.done), 64'(0));
      check_output("async_rst_ovf", 64'(bus.overflow), 64'(0));
      check_output("async_rst_seg", 64'(seg), 64'h7F);
      check_output("async_rst_en", 64'(digit_en), 64'(0));
      idle(2);
      #2 reset_n = 1'b1;
   endtask

   initial begin
      int n;
      reset_n   = 1'b0;
      bus.load  = 1'b0;
      bus.value = '0;
      lz_blank  = 1'b0;
      blank     = 1'b0;
      idle(3);
      #2 reset_n = 1'b1;
      idle(2 * SD * D);

      apply_stimulus(32'd1234);
      apply_stimulus(32'd56789);
      apply_stimulus(32'd9999);
      lz_blank = 1'b1;
      apply_stimulus(32'd7);
      apply_stimulus(32'd0);
      apply_stimulus(32'd1000);
      lz_blank = 1'b0;
      apply_stimulus(32'hFFFF_FFFF);

      // Mid-conversion load is ignored; a load right after done is accepted.
      @(negedge clk);
      bus.value = 32'd4321; bus.load = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
      idle(10);
      bus.value = 32'd1111; bus.load = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
      n = 0;
      while (bus.done !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_output("done_wait_timeout", 64'(bus.done), 64'(1));
      bus.value = 32'd2468; bus.load = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
      wait_ready();
      idle(2 * SD * D);

      // Load held high: accepted again on every final shift cycle.
      @(negedge clk);
      bus.load = 1'b1;
      for (int i = 0; i < 3 * W; i++) begin
         bus.value = $urandom;
         @(negedge clk);
      end
      bus.load = 1'b0;
      wait_ready();
      idle(SD * D);

      // Randomized loads, values and blanking controls.
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         bus.load  = ($urandom_range(0, 5) == 0);
         bus.value = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 12000)) : W'($urandom);
         if ($urandom_range(0, 39) == 0) lz_blank = ~lz_blank;
         if ($urandom_range(0, 59) == 0) blank = ~blank;
      end
      bus.load = 1'b0;
      blank    = 1'b0;
      wait_ready();
      idle(SD * D);

      // Reset in the middle of a conversion while blanked.
      @(negedge clk);
      bus.value = 32'd8765; bus.load = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
      idle(10);
      blank = 1'b1;
      do_reset();
      blank = 1'b0;
      idle(3 * W);

      apply_stimulus(32'd10000);
      idle(5);
      check_output("scoreboard_drain", 64'(sb_q.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
